ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests and the forwarded operand values presented in EX.
- Owns the architectural HI/LO registers.
- Raises a stall to the hazard logic while busy, so ID/EX and earlier stages hold until the result is available.

Parameters:
- XLEN, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == XLEN.

Ports:
- Clk  input  1  pipeline clock; all state updates on rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- flush  input  1  cancels any in-progress operation; HI/LO keep their last committed values.
- start  input  1  EX holds a MULT/MULTU/DIV/DIVU instruction this cycle.
- md_op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A_in  input  XLEN  rs operand (multiplicand or dividend), already forwarded.
- B_in  input  XLEN  rt operand (multiplier or divisor), already forwarded.
- mthi  input  1  write A_in to HI.
- mtlo  input  1  write A_in to LO.
- mf_req  input  1  EX holds MFHI or MFLO.
- mf_sel_hi  input  1  1 = MFHI, 0 = MFLO.
- mf_data  output  XLEN  combinational: mf_sel_hi ? HI : LO.
- hi  output  XLEN  HI register.
- lo  output  XLEN  LO register.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse on the edge HI/LO are committed by an operation.
- stall  output  1  combinational: busy & (start | mthi | mtlo | mf_req).

Behaviour:
- Reset (async, Rst_n low): state=IDLE, HI=0, LO=0, counter=0, internal datapath registers 0, busy=0, done=0. Reset asserted mid-operation aborts immediately with no HI/LO commit.
- States:
  - IDLE → CALC on start & !flush. Edge E0 latches |A|, |B| (signed ops take magnitudes; unsigned ops use raw values), result sign bits, op and divide-by-zero flag. Counter=0.
  - CALC: one radix-2 step per cycle.
    - Multiply: shift-add into a 2*XLEN product register.
    - Divide: restoring; shift remainder:quotient left, subtract divisor, keep the difference if non-negative and set quotient bit.
    - Edges E1..E32 perform the 32 steps. At E32 (counter==XLEN-1) → FIX.
  - FIX, at edge E33:
    - Apply signs. MULT product is negated if signs differ. DIV quotient is negated if signs differ; remainder takes the dividend's sign.
    - Write HI/LO: mult HI=product[63:32], LO=product[31:0]; div LO=quotient, HI=remainder.
    - done=1 for this cycle only. → IDLE.
- Latency: start seen at E0, busy high from E0 through E33, result readable via mf_data in the cycle after E33. Total 33 busy cycles.
- Divide by zero: LO=all ones, HI=dividend (raw A_in). Same 33-cycle latency.
- Signed overflow DIV 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0. This is the natural result of magnitude arithmetic and needs no special case.
- flush while CALC/FIX: → IDLE next edge, no HI/LO write, no done. flush in IDLE with start: start ignored.
- mthi/mtlo act only when IDLE and not stalled: write HI/LO at the edge. If both are asserted, both write. While busy they are stalled and perform no write.
- start in the same cycle as mthi/mtlo cannot occur by decode. If it does occur, start has priority and the mt writes are dropped.
- start while busy: stalled; the hazard unit re-presents it. The unit must not re-latch operands.
- MF read while busy is stalled. In IDLE, mf_data reflects HI/LO immediately, including the value written by FIX on the preceding edge.

Test Plan:
- Reset mid-CALC (Rst_n low at E10) → HI=LO=0, busy=0 asynchronously, done never pulses; a subsequent MULTU 2*3 → LO=6, HI=0.
- MULT A=0xFFFFFFFD (-3), B=7 → busy 33 cycles, done at E33, HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULTU 0xFFFFFFFF*0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 100/0 → LO=0xFFFFFFFF, HI=0x00000064 after 33 cycles.
- MFLO asserted at E5 of a MULT → stall=1 through E33, deasserts the cycle after; mf_data then equals the new LO. MTHI 0x1234 while busy is ignored; MTHI in IDLE → hi=0x00001234 next edge.
- flush at E20 of DIVU 10/3 with prior HI=0xAA, LO=0xBB → IDLE at E21, HI/LO unchanged, no done pulse.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage request/response bundle between the pipeline and the mul/div unit.
interface ex_muldiv_if #(parameter int XLEN = 32);
   logic            flush;
   logic            start;
   logic [1:0]      md_op;
   logic [XLEN-1:0] A_in;
   logic [XLEN-1:0] B_in;
   logic            mthi;
   logic            mtlo;
   logic            mf_req;
   logic            mf_sel_hi;
   logic [XLEN-1:0] mf_data;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic            busy;
   logic            done;
   logic            stall;
   modport slave (
      input  flush, start, md_op, A_in, B_in, mthi, mtlo, mf_req, mf_sel_hi,
      output mf_data, hi, lo, busy, done, stall
   );
   modport master (
      output flush, start, md_op, A_in, B_in, mthi, mtlo, mf_req, mf_sel_hi,
      input  mf_data, hi, lo, busy, done, stall
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative radix-2 multiply / restoring divide owning HI/LO.
module ex_muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic        Clk,
   input  logic        Rst_n,
   ex_muldiv_if.slave  md
);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d, step, prod;
   logic [XLEN-1:0]   m_q, m_d, araw_q, araw_d, hi_q, hi_d, lo_q, lo_d;
   logic [XLEN-1:0]   abs_a, abs_b, quo, rem, fix_hi, fix_lo;
   logic              mul_q, mul_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;
   logic              sa, sb, ge;
   logic [XLEN:0]     madd;
   assign sa    = !md.md_op[0] && md.A_in[XLEN-1];
   assign sb    = !md.md_op[0] && md.B_in[XLEN-1];
   assign abs_a = sa ? -md.A_in : md.A_in;
   assign abs_b = sb ? -md.B_in : md.B_in;
   // acc holds product (multiply) or remainder:quotient (divide)
   assign madd  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
   assign ge    = acc_q[2*XLEN-1:XLEN-1] >= {1'b0, m_q};
   assign step  = mul_q ? {madd, acc_q[XLEN-1:1]}
                : ge    ? {acc_q[2*XLEN-2:XLEN-1] - m_q, acc_q[XLEN-2:0], 1'b1}
                :         {acc_q[2*XLEN-2:0], 1'b0};
   assign prod   = neg_q ? -acc_q : acc_q;
   assign quo    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   assign rem    = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
   assign fix_hi = dz_q ? araw_q : mul_q ? prod[2*XLEN-1:XLEN] : rem;
   assign fix_lo = dz_q ? '1 : mul_q ? prod[XLEN-1:0] : quo;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      m_d     = m_q;
      araw_d  = araw_q;
      mul_d   = mul_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (md.start && !md.flush) begin
               state_d = CALC;
               cnt_d   = '0;
               mul_d   = !md.md_op[1];
               acc_d   = {{XLEN{1'b0}}, mul_d ? abs_b : abs_a};
               m_d     = mul_d ? abs_a : abs_b;
               neg_d   = sa ^ sb;
               rneg_d  = sa;
               araw_d  = md.A_in;
               dz_d    = md.md_op[1] && md.B_in == '0;
            end else if (!md.start) begin
               hi_d = md.mthi ? md.A_in : hi_q;
               lo_d = md.mtlo ? md.A_in : lo_q;
            end
         end
         CALC: begin
            state_d = md.flush ? IDLE : (cnt_q == CNT_W'(XLEN-1) ? FIX : CALC);
            cnt_d   = cnt_q + 1'b1;
            acc_d   = step;
         end
         FIX: begin
            state_d = IDLE;
            hi_d    = md.flush ? hi_q : fix_hi;
            lo_d    = md.flush ? lo_q : fix_lo;
            done_d  = !md.flush;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         m_q     <= '0;
         araw_q  <= '0;
         mul_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         m_q     <= m_d;
         araw_q  <= araw_d;
         mul_q   <= mul_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end
   assign md.busy    = state_q != IDLE;
   assign md.stall   = md.busy && (md.start || md.mthi || md.mtlo || md.mf_req);
   assign md.done    = done_q;
   assign md.hi      = hi_q;
   assign md.lo      = lo_q;
   assign md.mf_data = md.mf_sel_hi ? hi_q : lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed and random checks of ex_muldiv_unit against an arithmetic model of HI/LO.
module tb_ex_muldiv_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   always #5 clk = ~clk;
   ex_muldiv_if #(.XLEN(32)) md();
   ex_muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (.Clk(clk), .Rst_n(rst_n), .md(md));
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // returns {HI, LO} straight from the arithmetic definition of each op
   function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      case (op)
         2'd0:    return 64'(sa * sb);
         2'd1:    return {32'h0, a} * {32'h0, b};
         2'd2:    return (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
         default: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      endcase
   endfunction
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic clear_in();
      md.flush = 0; md.start = 0; md.md_op = 0; md.A_in = 0; md.B_in = 0;
      md.mthi = 0; md.mtlo = 0; md.mf_req = 0; md.mf_sel_hi = 0;
   endtask
   task automatic mt(input logic wh, input logic wl, input logic [31:0] v);
      md.mthi = wh; md.mtlo = wl; md.A_in = v;
      cyc();
      clear_in();
      if (wh) m_hi = v;
      if (wl) m_lo = v;
      chk("mt_hi", md.hi, m_hi);
      chk("mt_lo", md.lo, m_lo);
   endtask
   // mf_at: edge after which MFLO/MTHI/re-presented start hit the busy unit (-1 none)
   // flush_at: edge after which flush is raised (-1 none)
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int mf_at, input int flush_at);
      int k = 0;
      bit done_seen = 0;
      bit stall_ok = 1;
      logic [63:0] e;
      md.start = 1; md.md_op = op; md.A_in = a; md.B_in = b;
      cyc();
      md.start = 0;
      chk("busy_after_start", md.busy, 1);
      while (md.busy === 1'b1 && k < 40) begin
         if (k == mf_at) begin
            md.mf_req = 1; md.mf_sel_hi = 0; md.mthi = 1; md.A_in = 32'h1234;
            md.start = 1; md.B_in = 32'h5;
         end
         if (k == flush_at) md.flush = 1;
         #1;
         if (mf_at >= 0 && k >= mf_at && md.stall !== 1'b1) stall_ok = 0;
         if (md.done !== 1'b0) done_seen = 1;
         cyc();
         k++;
      end
      e = (flush_at >= 0) ? {m_hi, m_lo} : ref_md(op, a, b);
      chk("latency", 64'(k), 64'((flush_at >= 0) ? flush_at + 1 : 33));
      chk("done_pulse", md.done, 64'(flush_at < 0));
      chk("done_while_busy", 64'(done_seen), 0);
      chk("hi", md.hi, e[63:32]);
      chk("lo", md.lo, e[31:0]);
      if (mf_at >= 0) begin
         chk("stall_while_busy", 64'(stall_ok), 1);
         chk("stall_release", md.stall, 0);
         chk("mf_data_lo", md.mf_data, e[31:0]);
      end
      clear_in();
      m_hi = e[63:32];
      m_lo = e[31:0];
      cyc();
      chk("done_one_cycle", md.done, 0);
      chk("hi_hold", md.hi, m_hi);
   endtask
   initial begin
      clear_in();
      #3;
      chk("rst_busy", md.busy, 0);
      chk("rst_done", md.done, 0);
      chk("rst_hi", md.hi, 0);
      chk("rst_lo", md.lo, 0);
      chk("rst_stall", md.stall, 0);
      cyc();
      rst_n = 1;
      cyc();
      mt(1, 1, 32'h55);
      md.mf_sel_hi = 1;
      #1 chk("mfhi_idle", md.mf_data, m_hi);
      md.mf_sel_hi = 0;
      // asynchronous reset in the middle of a multiply
      md.start = 1; md.md_op = 2'd0; md.A_in = 7; md.B_in = 9;
      cyc();
      md.start = 0;
      repeat (9) cyc();
      chk("busy_mid_calc", md.busy, 1);
      rst_n = 0;
      #1;
      chk("async_rst_busy", md.busy, 0);
      chk("async_rst_hi", md.hi, 0);
      chk("async_rst_lo", md.lo, 0);
      m_hi = 0; m_lo = 0;
      repeat (2) cyc();
      chk("rst_no_done", md.done, 0);
      rst_n = 1;
      cyc();
      run_op(2'd1, 2, 3, -1, -1);
      run_op(2'd0, 32'hFFFF_FFFD, 7, -1, -1);
      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
      run_op(2'd2, 32'hFFFF_FFF9, 2, -1, -1);
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
      run_op(2'd3, 100, 0, -1, -1);
      run_op(2'd2, 32'hFFFF_FF00, 0, -1, -1);
      run_op(2'd0, 32'h0001_2345, 32'hFFFF_0001, 5, -1);
      mt(1, 0, 32'h1234);
      mt(1, 0, 32'hAA);
      mt(0, 1, 32'hBB);
      run_op(2'd3, 10, 3, -1, 20);
      for (int i = 0; i < 12; i++) begin
         logic [1:0] op;
         logic [31:0] a, b;
         op = 2'($urandom_range(0, 3));
         a = $urandom;
         b = ($urandom_range(0, 5) == 0) ? 32'(0)
           : ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         run_op(op, a, b, -1, -1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
